// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator:
// FSM state encoding and the result codes held between compares.
package serial_cmp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SCAN = ST_SCAN,
    DONE = ST_DONE
  } state_t;

  // CMP_NONE covers the window before the first result and while a new scan runs
  localparam logic [1:0] CMP_NONE = 2'd0;
  localparam logic [1:0] CMP_EQ   = 2'd1;
  localparam logic [1:0] CMP_GT   = 2'd2;
  localparam logic [1:0] CMP_LT   = 2'd3;

endpackage

// File: rtl/bit_cmp_cell.sv
// Single-bit ordered compare; invert flips the sense for a two's-complement sign bit.
module bit_cmp_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic invert,
  output logic bgt,
  output logic blt
);

  logic a_wins;
  logic b_wins;

  assign a_wins = a_bit & ~b_bit;
  assign b_wins = ~a_bit & b_bit;

  assign bgt = invert ? b_wins : a_wins;
  assign blt = invert ? a_wins : b_wins;

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator with start/done handshake.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN ends the scan at the first differing bit.
module serial_mag_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]   idx;
  logic [1:0]      result;
  logic            diff;

  logic a_bit;
  logic b_bit;
  logic invert;
  logic bgt;
  logic blt;
  logic last_bit;

  assign a_bit    = a_q[idx];
  assign b_bit    = b_q[idx];
  assign invert   = SIGNED && (idx == IDX_MSB);
  assign last_bit = (idx == '0);

  bit_cmp_cell u_cell (
    .a_bit  (a_bit),
    .b_bit  (b_bit),
    .invert (invert),
    .bgt    (bgt),
    .blt    (blt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (last_bit || (!diff && (bgt || blt))) begin
          state_nxt = DONE;
        end
`else
        if (last_bit) begin
          state_nxt = DONE;
        end
`endif
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Only the first (most significant) difference decides; diff locks it in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      idx    <= IDX_MSB;
      result <= CMP_NONE;
      diff   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            idx    <= IDX_MSB;
            result <= CMP_NONE;
            diff   <= 1'b0;
          end
        end
        SCAN: begin
          if (!diff && bgt) begin
            result <= CMP_GT;
            diff   <= 1'b1;
          end else if (!diff && blt) begin
            result <= CMP_LT;
            diff   <= 1'b1;
          end else if (!diff && last_bit) begin
            result <= CMP_EQ;
          end
          idx <= last_bit ? IDX_MSB : idx - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign gt   = (result == CMP_GT);
  assign lt   = (result == CMP_LT);
  assign eq   = (result == CMP_EQ);

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed self-checking bench for serial_mag_comparator (WIDTH=4, unsigned and signed instances).
module tb_serial_mag_comparator;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam int LAT_T1 = 1;
  localparam int LAT_T2 = 1;
  localparam int LAT_T5 = 3;
`else
  localparam int LAT_T1 = 4;
  localparam int LAT_T2 = 4;
  localparam int LAT_T5 = 4;
`endif
  localparam int LAT_EQ = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy, done, gt, lt, eq;
  logic       busy_s, done_s, gt_s, lt_s, eq_s;

  int total;
  int bad;

  serial_mag_comparator #(.WIDTH(4), .SIGNED(1'b0)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .lt    (lt),
    .eq    (eq)
  );

  serial_mag_comparator #(.WIDTH(4), .SIGNED(1'b1)) dut_s (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy_s),
    .done  (done_s),
    .gt    (gt_s),
    .lt    (lt_s),
    .eq    (eq_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents operands with start for exactly one accepting edge; returns at the following negedge
  task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen; -1 on timeout
  task automatic wait_done(output int n);
    n = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    total++;
    if ({busy, done, gt, lt, eq} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %b want 00000", {busy, done, gt, lt, eq});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, gt, lt, eq} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL idle_after_reset: got %b want 00000", {busy, done, gt, lt, eq});
    end
  endtask

  task automatic test_unsigned_gt;
    int n;
    applyStimulus(4'b1010, 4'b0110);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL t1_busy: got %b want 1", busy);
    end
    wait_done(n);
    total++;
    if (n !== LAT_T1) begin
      bad++;
      $display("[TB] FAIL t1_latency: got %0d want %0d", n, LAT_T1);
    end
    total++;
    if ({gt, lt, eq} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL t1_result: got gt/lt/eq=%b want 100", {gt, lt, eq});
    end
  endtask

  task automatic test_signed;
    int n;
    applyStimulus(4'b1000, 4'b0111);
    wait_done(n);
    total++;
    if (n !== LAT_T2) begin
      bad++;
      $display("[TB] FAIL t2_latency: got %0d want %0d", n, LAT_T2);
    end
    total++;
    if ({gt, lt, eq} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL t2_unsigned: got gt/lt/eq=%b want 100", {gt, lt, eq});
    end
    total++;
    if ({done_s, gt_s, lt_s, eq_s} !== 4'b1010) begin
      bad++;
      $display("[TB] FAIL t2_signed: got done/gt/lt/eq=%b want 1010", {done_s, gt_s, lt_s, eq_s});
    end
  endtask

  task automatic test_equal;
    int n;
    applyStimulus(4'b0101, 4'b0101);
    wait_done(n);
    total++;
    if (n !== LAT_EQ) begin
      bad++;
      $display("[TB] FAIL t3_latency: got %0d want %0d", n, LAT_EQ);
    end
    total++;
    if ({gt, lt, eq} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL t3_result: got gt/lt/eq=%b want 001", {gt, lt, eq});
    end
    total++;
    if ({gt_s, lt_s, eq_s} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL t3_signed_result: got gt/lt/eq=%b want 001", {gt_s, lt_s, eq_s});
    end
  endtask

  task automatic test_ignore_inputs;
    int dones;
    logic gt_at;
    dones = 0;
    gt_at = 1'b0;
    applyStimulus(4'b0011, 4'b0010);
    a = 4'b0000;
    b = 4'b1111;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) start = 1'b1;
      if (c == 2) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        gt_at = gt;
      end
    end
    total++;
    if (dones !== 1) begin
      bad++;
      $display("[TB] FAIL t4_done_count: got %0d want 1", dones);
    end
    total++;
    if (gt_at !== 1'b1) begin
      bad++;
      $display("[TB] FAIL t4_gt_at_done: got %b want 1", gt_at);
    end
    total++;
    if ({busy, gt, lt, eq} !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL t4_held: got busy/gt/lt/eq=%b want 0100", {busy, gt, lt, eq});
    end
  endtask

  task automatic test_abort;
    int n;
    int dones;
    dones = 0;
    applyStimulus(4'b0101, 4'b0011);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, gt, lt, eq} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL t5_abort: got %b want 00000", {busy, done, gt, lt, eq});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done !== 1'b0) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("[TB] FAIL t5_no_done: got %0d pulses want 0", dones);
    end
    applyStimulus(4'b0001, 4'b0010);
    wait_done(n);
    total++;
    if (n !== LAT_T5) begin
      bad++;
      $display("[TB] FAIL t5_latency: got %0d want %0d", n, LAT_T5);
    end
    total++;
    if ({gt, lt, eq} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL t5_result: got gt/lt/eq=%b want 010", {gt, lt, eq});
    end
  endtask

  task automatic test_back_to_back;
    int pos [8];
    int ndone;
    int idle_cnt;
    ndone = 0;
    idle_cnt = 0;
    @(negedge clk);
    a = 4'd9;
    b = 4'd9;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ndone == 1 && busy === 1'b0) idle_cnt++;
      if (done === 1'b1) begin
        if (ndone < 8) pos[ndone] = c;
        ndone++;
        total++;
        if (eq !== 1'b1) begin
          bad++;
          $display("[TB] FAIL t6_eq_run%0d: got %b want 1", ndone, eq);
        end
      end
    end
    start = 1'b0;
    total++;
    if (ndone !== 5) begin
      bad++;
      $display("[TB] FAIL t6_done_count: got %0d want 5", ndone);
    end
    if (ndone >= 3) begin
      total++;
      if ((pos[1] - pos[0]) !== 6 || (pos[2] - pos[1]) !== 6) begin
        bad++;
        $display("[TB] FAIL t6_period: got %0d,%0d want 6,6", pos[1] - pos[0], pos[2] - pos[1]);
      end
    end
    total++;
    if (idle_cnt !== 1) begin
      bad++;
      $display("[TB] FAIL t6_idle_gap: got %0d want 1", idle_cnt);
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_unsigned_gt();
    test_signed();
    test_equal();
    test_ignore_inputs();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
